elevator_controller: RTL and testbench
======================================

Name: elevator_controller

Overview:
- Sequencing controller for the 8-floor elevator simulator datapath.
- Latches hall and car call buttons into pending-call registers and runs a collective-control state machine.
- Drives current floor, direction, move and door-open outputs.
- Its pending-call outputs and floor/direction outputs are the call_in/call_up/call_down, cur_floor and direction inputs of the simulator/floor-check logic.

Parameters:
- TRAVEL_CYCLES, 2, cycles spent in MOVING per one-floor step (>=1).
- DOOR_CYCLES, 4, cycles door_open is held per stop (>=1).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- btn_in  in  8  car buttons, one-cycle pulses, bit = floor.
- btn_up  in  8  hall up buttons; bit 7 ignored.
- btn_down  in  8  hall down buttons; bit 0 ignored.
- call_in  out  8  pending car calls (registered).
- call_up  out  8  pending up calls (registered).
- call_down  out  8  pending down calls (registered).
- cur_floor  out  3  current floor, 0..7.
- direction  out  1  1 = up, 0 = down.
- move  out  1  high while in MOVING.
- open  out  1  door open, high while in DOOR_OPEN.
- idle  out  1  high while in IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, cur_floor=0, direction=1, call_* = 0, move=0, open=0, idle=1, counter=0.
- Definitions: here = call_in[f] | call_up[f] | call_down[f] for f = cur_floor. ahead_up = any pending bit (any of the 3 vectors) at a floor > f. ahead_dn = the same for floors < f.
- Latching: btn_* pulses are ORed into call_* on the next edge; latency is one cycle. Masked bits (btn_up[7], btn_down[0]) never set.
- Clearing: a clear and a set on the same bit in the same cycle: clear wins only on that serviced bit; all other sets are still latched.
- States: IDLE, MOVING, ARRIVE, DOOR_OPEN, DOOR_CLOSE.
- IDLE:
  - if here: go to DOOR_OPEN and clear all three bits at f.
  - elif (direction & ahead_up) | (~direction & ahead_dn): stay in direction, go to MOVING.
  - elif the opposite side has calls: flip direction, go to MOVING.
  - else stay in IDLE.
  - The decision is made from registered call_*, so a press at edge N leaves IDLE at edge N+1.
- MOVING:
  - move=1 for exactly TRAVEL_CYCLES cycles.
  - On the last cycle's edge, cur_floor += 1 (up) or -= 1 (down), then go to ARRIVE.
  - cur_floor is never driven outside 0..7, because MOVING is entered only toward a pending call.
- ARRIVE (1 cycle): the stop is serviced if any of these hold:
  - call_in[f];
  - direction & call_up[f];
  - ~direction & call_down[f];
  - nothing ahead in direction and here.
  - If serviced: clear call_in[f] plus the direction-matching hall bit, or both hall bits at a turnaround; go to DOOR_OPEN.
  - Else go to MOVING, same direction.
- DOOR_OPEN:
  - open=1 for exactly DOOR_CYCLES cycles.
  - Presses of btn_in[f] and the direction-matching hall button at f are absorbed (not latched).
  - Opposite-direction hall presses at f are latched.
  - Go to DOOR_CLOSE.
- DOOR_CLOSE (1 cycle):
  - calls ahead in direction -> MOVING;
  - else calls behind -> flip direction, MOVING;
  - else if here (opposite hall call left at f) -> flip direction, DOOR_OPEN, clear it;
  - else IDLE.
- Outputs are registered decodes of state; no combinational path from btn_* to outputs.
- Per-floor step cost: TRAVEL_CYCLES + 1 cycles (including ARRIVE).
- Counter is shared by MOVING and DOOR_OPEN; it reloads on each state entry.

Test Plan:
- Reset mid-MOVING (floor 2, count 1) -> outputs go to reset values immediately without waiting for a clock edge; call_*=0 after release.
- From reset, pulse btn_in[3] -> call_in=0x08 next cycle; move=1 for 2 cycles per floor; cur_floor 1,2,3 at 3-cycle spacing; then open=1 for 4 cycles; call_in=0x00; then idle=1.
- At floor 0, pulse btn_up[7] and btn_down[0] -> call_up=0x00 and call_down=0x00; elevator stays in IDLE.
- Moving up from 0 toward btn_in[5], press btn_down[2] while passing -> no stop at floor 2 going up. Stop at 5; reverse; stop at 2 with call_down cleared; then IDLE.
- Idle at floor 4, simultaneous btn_in[6] and btn_in[1] with direction=1 -> serves 6 first, then reverses to 1; direction=0 on the leg toward 1.
- Door open at floor 3 going up; press btn_in[3] and btn_down[3] -> btn_in absorbed; call_down[3] latched. DOOR_CLOSE with nothing else pending -> direction=0, door reopens 4 cycles, call_down=0x00.

Source files
------------

// File: rtl/elevator_controller_if.sv
// Button inputs and call/position/status outputs of the elevator controller.
interface elevator_controller_if;
  logic [7:0] btn_in;
  logic [7:0] btn_up;
  logic [7:0] btn_down;
  logic [7:0] call_in;
  logic [7:0] call_up;
  logic [7:0] call_down;
  logic [2:0] cur_floor;
  logic       direction;
  logic       move;
  logic       open;
  logic       idle;

  modport master (
    output btn_in, btn_up, btn_down,
    input  call_in, call_up, call_down, cur_floor, direction, move, open, idle
  );

  modport slave (
    input  btn_in, btn_up, btn_down,
    output call_in, call_up, call_down, cur_floor, direction, move, open, idle
  );
endinterface

// File: rtl/elevator_controller.sv
// Collective-control sequencer for an 8-floor elevator: latches calls,
// walks floors, and runs the door cycle.
module elevator_controller #(
  parameter int unsigned TRAVEL_CYCLES = 2,
  parameter int unsigned DOOR_CYCLES   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  elevator_controller_if.slave bus
);

  localparam int unsigned CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MOVING, S_ARRIVE, S_DOOR_OPEN, S_DOOR_CLOSE
  } state_t;

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [2:0]       floor_q, nxt_floor;
  logic             dir_q, nxt_dir;
  logic [7:0]       call_in_q, call_up_q, call_down_q;
  logic             move_q, open_q, idle_q;

  logic [7:0] pend, fbit, above, below;
  logic [7:0] clr_in, clr_up, clr_dn, abs_in, abs_up, abs_dn;
  logic       here, ahead_up, ahead_dn, fwd, back, serviced;

  // Call-position helpers relative to the current floor.
  always_comb begin
    pend     = call_in_q | call_up_q | call_down_q;
    fbit     = 8'd1 << floor_q;
    above    = ~(8'(fbit << 1) - 8'd1);
    below    = fbit - 8'd1;
    here     = |(pend & fbit);
    ahead_up = |(pend & above);
    ahead_dn = |(pend & below);
    fwd      = dir_q ? ahead_up : ahead_dn;
    back     = dir_q ? ahead_dn : ahead_up;
    serviced = call_in_q[floor_q] | (dir_q & call_up_q[floor_q]) |
               (~dir_q & call_down_q[floor_q]) | (~fwd & here);
  end

  // Next-state, counter, floor/direction and per-bit clear/absorb decisions.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_floor = floor_q;
    nxt_dir   = dir_q;
    clr_in    = '0;
    clr_up    = '0;
    clr_dn    = '0;
    abs_in    = '0;
    abs_up    = '0;
    abs_dn    = '0;
    case (state)
      S_IDLE: begin
        if (here) begin
          nxt_state = S_DOOR_OPEN;
          nxt_cnt   = DOOR_LOAD;
          clr_in    = fbit;
          clr_up    = fbit;
          clr_dn    = fbit;
        end else if (fwd) begin
          nxt_state = S_MOVING;
          nxt_cnt   = TRAVEL_LOAD;
        end else if (back) begin
          nxt_state = S_MOVING;
          nxt_cnt   = TRAVEL_LOAD;
          nxt_dir   = ~dir_q;
        end
      end
      S_MOVING: begin
        if (cnt == '0) begin
          nxt_state = S_ARRIVE;
          nxt_floor = dir_q ? 3'(floor_q + 3'd1) : 3'(floor_q - 3'd1);
        end else begin
          nxt_cnt = cnt - CNT_W'(1);
        end
      end
      S_ARRIVE: begin
        if (serviced) begin
          nxt_state = S_DOOR_OPEN;
          nxt_cnt   = DOOR_LOAD;
          clr_in    = fbit;
          // At a turnaround both hall calls at this floor are answered.
          if (!fwd || dir_q)  clr_up = fbit;
          if (!fwd || !dir_q) clr_dn = fbit;
        end else begin
          nxt_state = S_MOVING;
          nxt_cnt   = TRAVEL_LOAD;
        end
      end
      S_DOOR_OPEN: begin
        abs_in = fbit;
        if (dir_q) abs_up = fbit;
        else       abs_dn = fbit;
        if (cnt == '0) nxt_state = S_DOOR_CLOSE;
        else           nxt_cnt   = cnt - CNT_W'(1);
      end
      S_DOOR_CLOSE: begin
        if (fwd) begin
          nxt_state = S_MOVING;
          nxt_cnt   = TRAVEL_LOAD;
        end else if (back) begin
          nxt_state = S_MOVING;
          nxt_cnt   = TRAVEL_LOAD;
          nxt_dir   = ~dir_q;
        end else if (here) begin
          nxt_state = S_DOOR_OPEN;
          nxt_cnt   = DOOR_LOAD;
          nxt_dir   = ~dir_q;
          clr_in    = fbit;
          clr_up    = fbit;
          clr_dn    = fbit;
        end else begin
          nxt_state = S_IDLE;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      floor_q     <= '0;
      dir_q       <= 1'b1;
      call_in_q   <= '0;
      call_up_q   <= '0;
      call_down_q <= '0;
      move_q      <= 1'b0;
      open_q      <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      floor_q     <= nxt_floor;
      dir_q       <= nxt_dir;
      // Clear beats a same-cycle press only on the serviced bit.
      call_in_q   <= (call_in_q   | (bus.btn_in   & ~abs_in))           & ~clr_in;
      call_up_q   <= (call_up_q   | (bus.btn_up   & 8'h7F & ~abs_up))   & ~clr_up;
      call_down_q <= (call_down_q | (bus.btn_down & 8'hFE & ~abs_dn))   & ~clr_dn;
      move_q      <= (nxt_state == S_MOVING);
      open_q      <= (nxt_state == S_DOOR_OPEN);
      idle_q      <= (nxt_state == S_IDLE);
    end
  end

  assign bus.call_in   = call_in_q;
  assign bus.call_up   = call_up_q;
  assign bus.call_down = call_down_q;
  assign bus.cur_floor = floor_q;
  assign bus.direction = dir_q;
  assign bus.move      = move_q;
  assign bus.open      = open_q;
  assign bus.idle      = idle_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Self-checking bench for elevator_controller: call-latching vector table
// plus multi-floor scenarios scored against an expected-stop queue.
module tb_elevator_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;
  elevator_controller_if bus ();

  elevator_controller #(.TRAVEL_CYCLES(2), .DOOR_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b_in, b_up, b_dn;
    logic [7:0] e_in, e_up, e_dn;
    logic       e_move, e_open, e_idle;
  } vec_t;

  vec_t       vecs[6];
  vec_t       sb[$];
  logic [4:0] stops[$];
  int         passed = 0;
  int         total  = 0;
  logic       mon_en = 1'b0;
  logic       open_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Every door opening must match the next expected {dir, floor} stop.
  always @(posedge clock) begin
    logic [4:0] exp_stop;
    #1;
    if (mon_en && !reset && bus.open && !open_prev) begin
      exp_stop = (stops.size() > 0) ? stops.pop_front() : 5'h10;
      check("stop", {1'b0, bus.direction, bus.cur_floor}, 32'(exp_stop));
    end
    open_prev = bus.open;
  end

  task automatic drive(input logic [7:0] i, input logic [7:0] u, input logic [7:0] d);
    bus.btn_in = i; bus.btn_up = u; bus.btn_down = d;
  endtask

  task automatic pulse(input logic [7:0] i, input logic [7:0] u, input logic [7:0] d);
    drive(i, u, d);
    @(negedge clock);
    drive(8'h00, 8'h00, 8'h00);
  endtask

  task automatic apply_reset();
    drive(8'h00, 8'h00, 8'h00);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    stops.delete();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    repeat (2) @(negedge clock);
    while (!bus.idle && n < 400) begin @(negedge clock); n++; end
    check(name, 32'(bus.idle), 32'd1);
  endtask

  task automatic wait_open(input string name);
    int n = 0;
    while (!bus.open && n < 200) begin @(negedge clock); n++; end
    check(name, 32'(bus.open), 32'd1);
  endtask

  initial begin
    vec_t v;
    int   n;
    drive(8'h00, 8'h00, 8'h00);
    vecs[0] = '{8'h00, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hA4, 8'h12, 8'h48, 8'hA4, 8'h12, 8'h48, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 8'h81, 8'h00, 8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0};

    // Reset values.
    repeat (2) @(negedge clock);
    check("rst_floor", 32'(bus.cur_floor), 32'd0);
    check("rst_dir",   32'(bus.direction), 32'd1);
    check("rst_idle",  32'(bus.idle), 32'd1);
    check("rst_move_open", {bus.move, bus.open}, 32'd0);
    check("rst_calls", {bus.call_in, bus.call_up, bus.call_down}, 32'd0);

    // Latching and masking table, one press per fresh reset.
    for (int i = 0; i < 6; i++) begin
      apply_reset();
      sb.push_back(vecs[i]);
      pulse(vecs[i].b_in, vecs[i].b_up, vecs[i].b_dn);
      v = sb.pop_front();
      check($sformatf("v%0d_call_in", i),   32'(bus.call_in),   32'(v.e_in));
      check($sformatf("v%0d_call_up", i),   32'(bus.call_up),   32'(v.e_up));
      check($sformatf("v%0d_call_down", i), 32'(bus.call_down), 32'(v.e_dn));
      @(negedge clock);
      check($sformatf("v%0d_flags", i), {bus.move, bus.open, bus.idle},
            {v.e_move, v.e_open, v.e_idle});
    end
    mon_en = 1'b1;

    // Car call to floor 3: exact cycle-by-cycle trace.
    apply_reset();
    stops.push_back({1'b1, 3'd3});
    pulse(8'h08, 8'h00, 8'h00);
    check("t2_latch", 32'(bus.call_in), 32'h08);
    check("t2_idle0", 32'(bus.idle), 32'd1);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      check($sformatf("t2_move_k%0d", k),  32'(bus.move),  32'((k < 9) && (k % 3 != 0)));
      check($sformatf("t2_floor_k%0d", k), 32'(bus.cur_floor), (k < 9) ? 32'(k / 3) : 32'd3);
      check($sformatf("t2_open_k%0d", k),  32'(bus.open),  32'((k >= 10) && (k <= 13)));
      check($sformatf("t2_idle_k%0d", k),  32'(bus.idle),  32'(k >= 15));
      check($sformatf("t2_call_k%0d", k),  32'(bus.call_in), (k < 10) ? 32'h08 : 32'h00);
    end
    check("t2_stops_left", 32'(stops.size()), 32'd0);

    // Down call at 2 pressed while passing upward toward 5.
    apply_reset();
    stops.push_back({1'b1, 3'd5});
    stops.push_back({1'b0, 3'd2});
    pulse(8'h20, 8'h00, 8'h00);
    n = 0;
    while (bus.cur_floor != 3'd1 && n < 100) begin @(negedge clock); n++; end
    check("t4_reach1", 32'(bus.cur_floor), 32'd1);
    pulse(8'h00, 8'h00, 8'h04);
    check("t4_latch", 32'(bus.call_down), 32'h04);
    wait_idle("t4_idle");
    check("t4_floor", 32'(bus.cur_floor), 32'd2);
    check("t4_calls", {bus.call_in, bus.call_up, bus.call_down}, 32'd0);
    check("t4_stops_left", 32'(stops.size()), 32'd0);

    // Idle at 4 heading up; calls at 6 and 1 served in that order.
    apply_reset();
    stops.push_back({1'b1, 3'd4});
    pulse(8'h10, 8'h00, 8'h00);
    wait_idle("t5_idle4");
    check("t5_at4", {bus.direction, bus.cur_floor}, {1'b1, 3'd4});
    stops.push_back({1'b1, 3'd6});
    stops.push_back({1'b0, 3'd1});
    pulse(8'h42, 8'h00, 8'h00);
    wait_idle("t5_idle1");
    check("t5_at1", {bus.direction, bus.cur_floor}, {1'b0, 3'd1});
    check("t5_stops_left", 32'(stops.size()), 32'd0);

    // Presses at the open door: car call absorbed, opposite hall latched.
    apply_reset();
    stops.push_back({1'b1, 3'd3});
    pulse(8'h08, 8'h00, 8'h00);
    wait_open("t6_open");
    stops.push_back({1'b0, 3'd3});
    pulse(8'h08, 8'h00, 8'h08);
    check("t6_absorb_in", 32'(bus.call_in), 32'h00);
    check("t6_latch_dn", 32'(bus.call_down), 32'h08);
    wait_idle("t6_idle");
    check("t6_dir", 32'(bus.direction), 32'd0);
    check("t6_call_dn", 32'(bus.call_down), 32'h00);
    check("t6_stops_left", 32'(stops.size()), 32'd0);

    // Asynchronous reset while moving at floor 2.
    apply_reset();
    pulse(8'h20, 8'h00, 8'h00);
    n = 0;
    while (!(bus.cur_floor == 3'd2 && bus.move) && n < 100) begin @(negedge clock); n++; end
    check("t1_mid_move", {bus.move, bus.cur_floor}, {1'b1, 3'd2});
    #2 reset = 1'b1;
    #1;
    check("t1_async_floor", 32'(bus.cur_floor), 32'd0);
    check("t1_async_flags", {bus.move, bus.open, bus.idle, bus.direction}, 32'b0011);
    check("t1_async_calls", 32'(bus.call_in), 32'h00);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("t1_post_calls", {bus.call_in, bus.call_up, bus.call_down}, 32'd0);
    check("t1_post_idle", 32'(bus.idle), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
